seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/mult_pkg.sv | 5 +
 rtl/adder_n.sv | 13 +
 rtl/seq_multiplier.sv | 60 ++++++
 tb/tb_seq_multiplier.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM state type and default operand width for the sequential multiplier
package mult_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/adder_n.sv
// adder_n: WIDTH-bit combinational adder with carry out
module adder_n
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);
  assign {carry, sum} = {1'b0, a} + {1'b0, m};
endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: unsigned shift-add multiplier, one partial product per cycle, valid/ready handshakes
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   m,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t state, state_n;
  logic [WIDTH-1:0] a_q, upper, lower, addend, sum;
  logic [CW-1:0] cnt;
  logic carry, last;
  assign addend = lower[0] ? a_q : '0;
  assign last = cnt == CW'(WIDTH);
  adder_n #(.WIDTH(WIDTH)) u_add (.a(upper), .m(addend), .sum(sum), .carry(carry));
  always_comb begin
    state_n = state == IDLE ? (in_valid ? CALC : IDLE)
            : state == CALC ? (last ? DONE : CALC)
            : (out_ready ? IDLE : DONE);
    in_ready = state == IDLE;
    out_valid = state == DONE;
    busy = state != IDLE;
  end
  // lower starts as the multiplier and fills with product bits as it shifts out
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a_q <= '0;
      upper <= '0;
      lower <= '0;
      cnt <= '0;
      product <= '0;
    end else begin
      state <= state_n;
      if (in_valid && in_ready) begin
        a_q <= a;
        lower <= m;
        upper <= '0;
        cnt <= '0;
      end else if (state == CALC) begin
        if (last) product <= {upper, lower};
        else begin
          upper <= {carry, sum[WIDTH-1:1]};
          lower <= {sum[0], lower[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: table-driven and scoreboarded checks of seq_multiplier at WIDTH 8 and 16
module tb_seq_multiplier;
  typedef struct {
    logic [7:0]  a;
    logic [7:0]  m;
    logic [15:0] p;
  } vec_t;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 0;
  logic [7:0] a = 0, m = 0;
  logic in_ready, out_valid, busy;
  logic [15:0] product;
  logic b_valid = 0, b_or = 0, b_ir, b_ov, b_busy;
  logic [15:0] b_a = 0, b_m = 0;
  logic [31:0] b_p;
  logic s_valid = 0, s_or = 0;
  logic [15:0] s_ir, s_ov, s_busy;
  logic [7:0] s_a [16];
  logic [7:0] s_m [16];
  logic [15:0] s_p [16];
  int checks = 0, failures = 0;
  logic [15:0] exp_q [$];
  vec_t tbl [8];

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .a(a), .m(m),
    .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
  );
  seq_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .in_valid(b_valid), .in_ready(b_ir), .a(b_a), .m(b_m),
    .out_valid(b_ov), .out_ready(b_or), .product(b_p), .busy(b_busy)
  );
  for (genvar g = 0; g < 16; g++) begin : g_lane
    seq_multiplier #(.WIDTH(8)) u_lane (
      .clk(clk), .reset(reset), .in_valid(s_valid), .in_ready(s_ir[g]), .a(s_a[g]), .m(s_m[g]),
      .out_valid(s_ov[g]), .out_ready(s_or), .product(s_p[g]), .busy(s_busy[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic run(input logic [7:0] ra, input logic [7:0] rm, input logic [15:0] rp);
    int n;
    check("in_ready_idle", in_ready, 1);
    a = ra;
    m = rm;
    in_valid = 1;
    tick();
    in_valid = 0;
    exp_q.push_back(rp);
    check("busy_calc", busy, 1);
    check("out_valid_calc", out_valid, 0);
    wait_valid(n);
    check("latency", n, 9);
    check("in_ready_done", in_ready, 0);
    check("product", product, exp_q.pop_front());
    out_ready = 1;
    tick();
    out_ready = 0;
    check("out_valid_after", out_valid, 0);
    check("busy_after", busy, 0);
  endtask

  initial begin
    int n;
    tbl[0] = '{8'd0, 8'd0, 16'h0000};
    tbl[1] = '{8'd255, 8'd255, 16'hFE01};
    tbl[2] = '{8'd1, 8'd1, 16'd1};
    tbl[3] = '{8'd128, 8'd2, 16'd256};
    tbl[4] = '{8'd15, 8'd17, 16'd255};
    tbl[5] = '{8'd255, 8'd1, 16'd255};
    tbl[6] = '{8'd170, 8'd85, 16'd14450};
    tbl[7] = '{8'd0, 8'd200, 16'd0};
    for (int i = 0; i < 16; i++) begin
      s_a[i] = 0;
      s_m[i] = 0;
    end
    repeat (2) tick();
    reset = 0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_product", product, 0);
    for (int i = 0; i < 8; i++) run(tbl[i].a, tbl[i].m, tbl[i].p);
    // backpressure: result must hold while out_ready is low
    a = 200;
    m = 3;
    in_valid = 1;
    tick();
    in_valid = 0;
    exp_q.push_back(16'd600);
    wait_valid(n);
    check("bp_latency", n, 9);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_product", product, 16'd600);
      tick();
    end
    check("bp_product_final", product, exp_q.pop_front());
    out_ready = 1;
    in_valid = 1;
    a = 1;
    m = 1;
    tick();
    out_ready = 0;
    in_valid = 0;
    check("bp_idle_out_valid", out_valid, 0);
    check("no_accept_on_handshake", in_ready, 1);
    // operands offered during CALC must be ignored
    a = 2;
    m = 3;
    in_valid = 1;
    tick();
    exp_q.push_back(16'd6);
    a = 7;
    m = 7;
    wait_valid(n);
    in_valid = 0;
    check("busy_ignore_latency", n, 9);
    check("busy_ignore_product", product, exp_q.pop_front());
    out_ready = 1;
    tick();
    out_ready = 0;
    tick();
    check("busy_ignore_idle", in_ready, 1);
    check("busy_ignore_no_busy", busy, 0);
    // reset at CALC step 4 discards the operation
    a = 9;
    m = 9;
    in_valid = 1;
    tick();
    in_valid = 0;
    repeat (4) tick();
    check("mid_calc_busy", busy, 1);
    reset = 1;
    tick();
    reset = 0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_product", product, 0);
    check("midrst_busy", busy, 0);
    run(8'd12, 8'd11, 16'd132);
    // reset wins over an input handshake on the same edge
    reset = 1;
    in_valid = 1;
    tick();
    reset = 0;
    in_valid = 0;
    check("rst_priority_ready", in_ready, 1);
    check("rst_priority_busy", busy, 0);
    // 16-bit instance
    b_a = 16'hFFFF;
    b_m = 16'hFFFF;
    b_valid = 1;
    tick();
    b_valid = 0;
    n = 0;
    while (!b_ov && n < 40) begin
      tick();
      n++;
    end
    check("w16_latency", n, 17);
    check("w16_product", b_p, 32'hFFFE0001);
    b_or = 1;
    tick();
    b_or = 0;
    check("w16_idle", b_ir, 1);
    // exhaustive 8-bit sweep over 16 parallel lanes
    for (int j = 0; j < 4096 && failures < 100; j++) begin
      for (int i = 0; i < 16; i++) begin
        s_a[i] = 8'(j >> 4);
        s_m[i] = 8'((j % 16) * 16 + i);
      end
      check("sweep_ready", &s_ir, 1);
      s_valid = 1;
      tick();
      s_valid = 0;
      check("sweep_busy", &s_busy, 1);
      n = 0;
      while (!(&s_ov) && n < 20) begin
        tick();
        n++;
      end
      check("sweep_latency", n, 9);
      for (int i = 0; i < 16; i++)
        check("sweep_product", s_p[i], 16'(s_a[i]) * 16'(s_m[i]));
      s_or = 1;
      tick();
      s_or = 0;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
